// File: rtl/dispatch_pipe_arbiter_if.sv
// Dispatch-queue-head / arbiter handshake bundle.
interface dispatch_pipe_arbiter_if #(
   parameter int unsigned DISP_WIDTH = 2,
   parameter int unsigned NUM_FUS    = 4
);
   localparam int unsigned PIPE_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

   logic                         stall;
   logic                         flush;
   logic [DISP_WIDTH-1:0]        slot_valid;
   logic [DISP_WIDTH*PIPE_W-1:0] slot_pipe;
   logic [NUM_FUS-1:0]           credit_return;
   logic [DISP_WIDTH-1:0]        slot_grant;
   logic [NUM_FUS-1:0]           pipe_free;
   logic                         credit_err;
   logic [15:0]                  collision_cnt;

   // Requester side: dispatch queues and pipe issue logic
   modport master (
      output stall, flush, slot_valid, slot_pipe, credit_return,
      input  slot_grant, pipe_free, credit_err, collision_cnt
   );

   // Arbiter side
   modport slave (
      input  stall, flush, slot_valid, slot_pipe, credit_return,
      output slot_grant, pipe_free, credit_err, collision_cnt
   );
endinterface

// File: rtl/dispatch_pipe_arbiter.sv
// Per-cycle dispatch arbiter: credit-tracked RS occupancy per pipe, one grant
// per pipe per cycle, rotating slot priority to break same-pipe collisions.
module dispatch_pipe_arbiter #(
   parameter int unsigned DISP_WIDTH = 2,
   parameter int unsigned NUM_FUS    = 4,
   parameter int unsigned RS_DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   dispatch_pipe_arbiter_if.slave bus
);
   localparam int unsigned PIPE_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
   localparam int unsigned CNT_W  = $clog2(RS_DEPTH + 1);
   localparam int unsigned RR_W   = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;

   logic [CNT_W-1:0]  credits     [NUM_FUS];
   logic [CNT_W-1:0]  credits_nxt [NUM_FUS];
   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   rr_ptr_nxt;
   logic              credit_err_q;
   logic              credit_err_nxt;
   logic [15:0]       collision_q;
   logic [15:0]       collision_nxt;
   logic [NUM_FUS-1:0] pipe_free_q;
   logic [NUM_FUS-1:0] pipe_free_nxt;

   logic [PIPE_W-1:0]     slot_pipe_a [DISP_WIDTH];
   logic [DISP_WIDTH-1:0] grant;
   logic [NUM_FUS-1:0]    taken;
   logic                  collided;
   logic [RR_W-1:0]       slot;
   logic [PIPE_W-1:0]     pipe;
   logic                  has_credit;

   // Unpack per-slot pipe targets
   for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_unpack
      assign slot_pipe_a[i] = bus.slot_pipe[i*PIPE_W +: PIPE_W];
   end

   // Grant selection in rotating priority order, one grant per pipe
   always_comb begin
      grant      = '0;
      taken      = '0;
      collided   = 1'b0;
      slot       = '0;
      pipe       = '0;
      has_credit = 1'b0;
      if (!rst && !bus.stall && !bus.flush) begin
         for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
            slot       = RR_W'((32'(rr_ptr) + k) % DISP_WIDTH);
            pipe       = slot_pipe_a[slot];
            has_credit = 1'b0;
            // Out-of-range pipe indices behave as a pipe with no credits
            if (32'(pipe) < NUM_FUS) begin
               has_credit = (credits[pipe] != '0);
            end
            if (bus.slot_valid[slot] && has_credit) begin
               if (taken[pipe]) begin
                  collided = 1'b1;
               end else begin
                  grant[slot] = 1'b1;
                  taken[pipe] = 1'b1;
               end
            end
         end
      end
   end

   // Next-state: credits, sticky error, rotating pointer, collision counter
   always_comb begin
      credit_err_nxt = credit_err_q;
      rr_ptr_nxt     = rr_ptr;
      collision_nxt  = collision_q;
      pipe_free_nxt  = '0;
      for (int p = 0; p < NUM_FUS; p++) begin
         credits_nxt[p] = credits[p];
         if (bus.flush) begin
            credits_nxt[p] = CNT_W'(RS_DEPTH);
         end else if (bus.credit_return[PIPE_W'(p)] && !taken[PIPE_W'(p)]) begin
            if (credits[p] == CNT_W'(RS_DEPTH)) begin
               credit_err_nxt = 1'b1;
            end else begin
               credits_nxt[p] = credits[p] + CNT_W'(1);
            end
         end else if (!bus.credit_return[PIPE_W'(p)] && taken[PIPE_W'(p)]) begin
            credits_nxt[p] = credits[p] - CNT_W'(1);
         end
         pipe_free_nxt[PIPE_W'(p)] = (credits_nxt[p] != '0);
      end
      if (bus.flush) begin
         rr_ptr_nxt = '0;
      end else if (collided) begin
         rr_ptr_nxt = (32'(rr_ptr) == DISP_WIDTH - 1) ? '0 : rr_ptr + RR_W'(1);
         if (collision_q != 16'hFFFF) begin
            collision_nxt = collision_q + 16'd1;
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_FUS; p++) begin
            credits[p] <= CNT_W'(RS_DEPTH);
         end
         rr_ptr       <= '0;
         credit_err_q <= 1'b0;
         collision_q  <= '0;
         pipe_free_q  <= '1;
      end else begin
         credits      <= credits_nxt;
         rr_ptr       <= rr_ptr_nxt;
         credit_err_q <= credit_err_nxt;
         collision_q  <= collision_nxt;
         pipe_free_q  <= pipe_free_nxt;
      end
   end

   assign bus.slot_grant    = grant;
   assign bus.pipe_free     = pipe_free_q;
   assign bus.credit_err    = credit_err_q;
   assign bus.collision_cnt = collision_q;
endmodule

// File: tb/tb_dispatch_pipe_arbiter.sv
// Bench for dispatch_pipe_arbiter: directed table, corner sequences, random vs model.
module tb_dispatch_pipe_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   dispatch_pipe_arbiter_if #(.DISP_WIDTH(2), .NUM_FUS(4)) bus ();

   dispatch_pipe_arbiter #(.DISP_WIDTH(2), .NUM_FUS(4), .RS_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state
   int m_cred [4];
   int m_rr;
   bit m_err;
   int m_coll;
   logic [1:0] last_grant;

   typedef struct {
      logic       st;
      logic       fl;
      logic [1:0] v;
      logic [3:0] p;
      logic [3:0] r;
      logic [1:0] eg;
      int         ecoll;
      logic [3:0] efree;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Grant rule: visit slots from rr, grant if valid with credits and pipe unused
   task automatic model_eval(input logic rs, input logic st, input logic fl,
                             input logic [1:0] v, input logic [3:0] p,
                             output logic [1:0] g, output bit coll);
      bit used [4];
      g = 2'b00;
      coll = 0;
      for (int j = 0; j < 4; j++) used[j] = 0;
      if (!rs && !st && !fl) begin
         for (int k = 0; k < 2; k++) begin
            int s;
            int pp;
            s  = (m_rr + k) % 2;
            pp = int'(p[s*2 +: 2]);
            if (v[s] && m_cred[pp] > 0) begin
               if (used[pp]) coll = 1;
               else begin
                  g[s] = 1'b1;
                  used[pp] = 1;
               end
            end
         end
      end
   endtask

   task automatic model_commit(input logic rs, input logic fl, input logic [3:0] r,
                               input logic [3:0] p, input logic [1:0] g, input bit coll);
      if (rs) begin
         for (int j = 0; j < 4; j++) m_cred[j] = 8;
         m_rr = 0; m_err = 0; m_coll = 0;
      end else if (fl) begin
         for (int j = 0; j < 4; j++) m_cred[j] = 8;
         m_rr = 0;
      end else begin
         for (int j = 0; j < 4; j++) begin
            int used_n;
            used_n = 0;
            for (int s = 0; s < 2; s++)
               if (g[s] && int'(p[s*2 +: 2]) == j) used_n++;
            m_cred[j] = m_cred[j] + int'(r[j]) - used_n;
            if (m_cred[j] > 8) begin
               m_cred[j] = 8;
               m_err = 1;
            end
         end
         if (coll) begin
            m_rr = (m_rr + 1) % 2;
            if (m_coll < 65535) m_coll++;
         end
      end
   endtask

   function automatic logic [3:0] model_free();
      logic [3:0] f;
      for (int j = 0; j < 4; j++) f[j] = (m_cred[j] != 0);
      return f;
   endfunction

   // One cycle: drive after posedge, check grant at negedge, check state after posedge
   task automatic step(input logic rs, input logic st, input logic fl, input logic [1:0] v,
                       input logic [3:0] p, input logic [3:0] r);
      logic [1:0] mg;
      bit mc;
      rst = rs;
      bus.stall = st;
      bus.flush = fl;
      bus.slot_valid = v;
      bus.slot_pipe = p;
      bus.credit_return = r;
      model_eval(rs, st, fl, v, p, mg, mc);
      @(negedge clk);
      last_grant = bus.slot_grant;
      chk("grant", 32'(last_grant), 32'(mg));
      @(posedge clk);
      #1;
      model_commit(rs, fl, r, p, mg, mc);
      chk("pipe_free", 32'(bus.pipe_free), 32'(model_free()));
      chk("credit_err", 32'(bus.credit_err), 32'(m_err));
      chk("collision_cnt", 32'(bus.collision_cnt), 32'(m_coll));
   endtask

   initial begin
      logic [3:0] rr_bits;
      for (int j = 0; j < 4; j++) m_cred[j] = 8;
      m_rr = 0; m_err = 0; m_coll = 0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.slot_valid = '0;
      bus.slot_pipe = '0;
      bus.credit_return = '0;

      // Directed table starting from reset
      tbl[0] = '{1'b0, 1'b0, 2'b11, 4'b1001, 4'b0000, 2'b11, 0, 4'b1111};
      tbl[1] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b01, 1, 4'b1111};
      tbl[2] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b10, 2, 4'b1111};
      tbl[3] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b01, 3, 4'b1111};
      tbl[4] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b10, 4, 4'b1111};
      tbl[5] = '{1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b00, 4, 4'b1111};
      tbl[6] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b01, 5, 4'b1111};
      tbl[7] = '{1'b0, 1'b0, 2'b01, 4'b0000, 4'b0001, 2'b01, 5, 4'b1111};
      tbl[8] = '{1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 2'b00, 5, 4'b1111};
      tbl[9] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 2'b01, 6, 4'b1111};

      @(posedge clk);
      #1;
      // Reset with valid requests pending: no grants, reset state
      step(1'b1, 1'b0, 1'b0, 2'b11, 4'b1001, 4'b0000);
      chk("rst_grant", 32'(last_grant), 32'd0);
      chk("rst_free", 32'(bus.pipe_free), 32'hF);
      chk("rst_coll", 32'(bus.collision_cnt), 32'd0);

      for (int i = 0; i < 10; i++) begin
         step(1'b0, tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].p, tbl[i].r);
         chk("tbl_grant", 32'(last_grant), 32'(tbl[i].eg));
         chk("tbl_coll", 32'(bus.collision_cnt), 32'(tbl[i].ecoll));
         chk("tbl_free", 32'(bus.pipe_free), 32'(tbl[i].efree));
         chk("tbl_err", 32'(bus.credit_err), 32'd0);
      end

      // Drain pipe3, blocked, then a single return admits exactly one grant
      step(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011, 4'b0000);
         chk("drain_grant", 32'(last_grant), 32'd1);
      end
      chk("drained_free3", 32'(bus.pipe_free[3]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011, 4'b0000);
         chk("blocked_grant", 32'(last_grant), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011, 4'b1000);
      chk("ret_cycle_grant", 32'(last_grant), 32'd0);
      chk("ret_free3", 32'(bus.pipe_free[3]), 32'd1);
      step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011, 4'b0000);
      chk("after_ret_grant", 32'(last_grant), 32'd1);
      chk("after_ret_free3", 32'(bus.pipe_free[3]), 32'd0);

      // Pipe2 at one credit: simultaneous grant and return keeps it at one
      step(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 4'b0100);
      chk("inc_dec_grant", 32'(last_grant), 32'd1);
      chk("inc_dec_free2", 32'(bus.pipe_free[2]), 32'd1);
      step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 4'b0000);
      chk("last_credit_grant", 32'(last_grant), 32'd1);
      chk("last_credit_free2", 32'(bus.pipe_free[2]), 32'd0);

      // Return at full credit sets a sticky error
      step(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0100);
      chk("overflow_err", 32'(bus.credit_err), 32'd1);
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 4'b0000);
      chk("sticky_err", 32'(bus.credit_err), 32'd1);

      // Flush from three credits restores the full eight
      step(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 2'b10, 4'b0100, 4'b0000);
      step(1'b0, 1'b0, 1'b1, 2'b10, 4'b0100, 4'b0010);
      chk("flush_grant", 32'(last_grant), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'b10, 4'b0100, 4'b0000);
         chk("post_flush_grant", 32'(last_grant), 32'd2);
         chk("post_flush_free1", 32'(bus.pipe_free[1]), (i == 7) ? 32'd0 : 32'd1);
      end

      // Random traffic, reset mid-stream, then more random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] r;
         logic rs;
         for (int j = 0; j < 4; j++) r[j] = ($urandom_range(0, 3) == 0);
         rs = (n == 20) || ($urandom_range(0, 299) == 0);
         step(rs, ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
              2'($urandom), 4'($urandom), r);
         if (n == 20) begin
            chk("mid_rst_grant", 32'(last_grant), 32'd0);
            chk("mid_rst_free", 32'(bus.pipe_free), 32'hF);
            chk("mid_rst_err", 32'(bus.credit_err), 32'd0);
            chk("mid_rst_coll", 32'(bus.collision_cnt), 32'd0);
         end
      end
      rr_bits = 4'(m_rr);
      chk("final_free", 32'(bus.pipe_free), 32'(model_free()));
      if (rr_bits > 4'd1) chk("model_rr_range", 32'(rr_bits), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
